// File: rtl/bin2gray_smooth.sv
// bin2gray_smooth: rebuilds a 12-bit gray level from a binary pixel stream.
// Each output is the density of set pixels in a sliding horizontal window
// of WIN = 2**WIN_LOG2 pixels. The window is confined to the current line.
//
// Ports:
//   iCLK   pixel clock, rising edge
//   iRST   synchronous active-low reset
//   iDVAL  input pixel valid
//   iDATA  binary pixel; any nonzero value is a set pixel
//   oDVAL  output valid, iDVAL delayed by one clock
//   oDATA  reconstructed gray level, held while oDVAL is low
//   oCOL   column of the pixel currently on oDATA
//
// Optional feature macro: BIN2GRAY_INVERT_EN
//   When defined, oDATA carries 4095 minus the window level (reset value
//   stays 0). oDVAL and oCOL timing are the same in both builds.

module bin2gray_smooth #(
  parameter int unsigned LINE_WIDTH = 640,
  parameter int unsigned WIN_LOG2   = 3,
  localparam int unsigned COL_W     = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iDVAL,
  input  logic [11:0]      iDATA,
  output logic             oDVAL,
  output logic [11:0]      oDATA,
  output logic [COL_W-1:0] oCOL
);

  localparam int unsigned DATA_W = 12;
  localparam int unsigned WIN    = 1 << WIN_LOG2;
  localparam int unsigned CNT_W  = WIN_LOG2 + 1;
  localparam int unsigned SHIFT  = DATA_W - WIN_LOG2;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIN);
  localparam logic [DATA_W-1:0] DATA_MAX = {DATA_W{1'b1}};

  logic [COL_W-1:0]  col_q,  col_d;
  logic [WIN-1:0]    sr_q,   sr_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              dval_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [COL_W-1:0]  ocol_q, ocol_d;

  logic              bit_c;
  logic              line_start_c;
  logic [DATA_W-1:0] level_c;

  // Input pixel reduced to one bit; column 0 starts a fresh window.
  assign bit_c        = |iDATA;
  assign line_start_c = (col_q == '0);

  // Column counter: advances only on valid pixels, wraps at end of line.
  always_comb begin
    col_d = col_q;
    if (iDVAL) begin
      if (col_q == COL_LAST) col_d = '0;
      else                   col_d = col_q + COL_W'(1);
    end
  end

  // Window shift register and its running popcount.
  // At line start the previous line's history is dropped, so the count is
  // just the new bit; otherwise the bit leaving the window is subtracted.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (iDVAL) begin
      if (line_start_c) begin
        sr_d  = WIN'(bit_c);
        cnt_d = CNT_W'(bit_c);
      end else begin
        sr_d  = {sr_q[WIN-2:0], bit_c};
        cnt_d = cnt_q + CNT_W'(bit_c) - CNT_W'(sr_q[WIN-1]);
      end
    end
  end

  // Map the updated count to a gray level; a full window saturates to
  // the maximum code instead of overflowing to zero.
  always_comb begin
    if (cnt_d == CNT_FULL) level_c = DATA_MAX;
    else                   level_c = DATA_W'(cnt_d) << SHIFT;
  end

  // Output data/column capture on valid pixels, hold otherwise.
  always_comb begin
    data_d = data_q;
    ocol_d = ocol_q;
    if (iDVAL) begin
`ifdef BIN2GRAY_INVERT_EN
      data_d = DATA_MAX - level_c;
`else
      data_d = level_c;
`endif
      ocol_d = col_q;
    end
  end

  // State and output registers; reset has priority over iDVAL.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      col_q  <= '0;
      sr_q   <= '0;
      cnt_q  <= '0;
      dval_q <= 1'b0;
      data_q <= '0;
      ocol_q <= '0;
    end else begin
      col_q  <= col_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      dval_q <= iDVAL;
      data_q <= data_d;
      ocol_q <= ocol_d;
    end
  end

  assign oDVAL = dval_q;
  assign oDATA = data_q;
  assign oCOL  = ocol_q;

endmodule

// File: doc/bin2gray_smooth.md
Name: bin2gray_smooth

Overview:
- Receiving end of the binary pixel stream produced by the gray-to-binary thresholder.
- Converts each 12-bit binary pixel (0 or 4095) back into a 12-bit gray level: the density of set pixels in a sliding horizontal window within the current line.
- Sits after the thresholder, before the display/capture path; same iDVAL-qualified streaming interface on both sides.

Parameters:
- LINE_WIDTH, 640, valid pixels per line; column counter wraps here.
- WIN_LOG2, 3, log2 of window length; WIN = 2^WIN_LOG2 (legal 1..4, so WIN is 2..16).

Ports:
- iCLK  input  1  pixel clock; all logic on rising edge.
- iRST  input  1  reset, synchronous, active-low.
- iDVAL  input  1  input pixel valid.
- iDATA  input  12  binary pixel; any nonzero value counts as 1.
- oDVAL  output  1  output pixel valid.
- oDATA  output  12  reconstructed gray level.
- oCOL  output  log2(LINE_WIDTH)  column index of the pixel currently on oDATA.

Behaviour:
- Reset: iRST=0 at a rising edge clears oDVAL, oDATA, oCOL, column counter, window shift register and window count to 0. Reset wins over iDVAL in the same cycle.
- Input bit: b = (iDATA != 0).
- Column counter col:
  - Increments on each iDVAL=1 cycle.
  - Wraps from LINE_WIDTH-1 to 0.
  - Holds when iDVAL=0, so gaps inside a line are allowed.
- Window:
  - WIN-bit shift register sr plus a (WIN_LOG2+1)-bit count, with count always equal to popcount(sr).
  - On iDVAL=1 with col != 0: sr <= {sr[WIN-2:0], b}; count <= count + b - sr[WIN-1].
  - On iDVAL=1 with col == 0 (line start): sr <= {0..0, b}; count <= b. History from the previous line is discarded; pixels left of column 0 count as 0.
  - iDVAL=0: sr and count hold.
- Output mapping, applied to the next count n (the value after this pixel is included):
  - n == WIN: 4095.
  - Otherwise: n << (12-WIN_LOG2).
  - For WIN=8: n=0..7 gives 0, 512, 1024, …, 3584; n=8 gives 4095.
- Timing, latency 1 clock:
  - oDVAL <= iDVAL every cycle.
  - On iDVAL=1: oDATA <= mapped value; oCOL <= current col.
  - On iDVAL=0: oDATA and oCOL hold their last values.
- Monotonic: a run of all-ones reaches 4095 exactly on the WIN-th pixel of the run.
- Line wrap with no gap, i.e. col LINE_WIDTH-1 then 0 on consecutive cycles: the column-0 pixel output depends only on its own b.
- Reset asserted mid-line: the next valid pixel after release is treated as column 0.

Optional Feature:
- Macro BIN2GRAY_INVERT_EN.
- Defined: oDATA carries 4095 minus the mapped value, so dark regions read bright, for inverted-polarity thresholds. Reset value of oDATA is still 0.
- Undefined: oDATA is the mapped value as specified.
- Timing, oDVAL and oCOL are identical in both builds.

Test Plan (WIN_LOG2=3, LINE_WIDTH=16 unless noted):
- Reset, then 8 consecutive valid pixels of 4095 -> oDATA sequence 512, 1024, 1536, 2048, 2560, 3072, 3584, 4095, each one cycle after its input; oCOL 0..7.
- Continue to 12 pixels of 4095, then pixels 12-15 = 0 -> oDATA 4095, 4095, 4095, 4095, then 3584, 3072, 2560, 2048.
- Line wrap: col 15 = 4095 with full window, next pixel (col 0) = 0 -> oDATA 0, oCOL 0; next pixel (col 1) = 4095 -> 512.
- Gaps: alternate iDVAL 1/0 with pixels 4095, 0, 4095, 0 -> oDVAL toggles; oDATA 512, hold, 512, hold, 1024, hold, 1024; col advances only on valid cycles.
- Nonzero non-4095 input: iDATA=1 treated as a set pixel -> 512 after a reset and column 0; assert iRST=0 at col 5 -> all outputs 0 next edge; next valid pixel reports oCOL 0.
- Build with BIN2GRAY_INVERT_EN, repeat the first scenario -> oDATA 3583, 3071, 2559, 2047, 1535, 1023, 511, 0.
